// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches RV-bit words, splits them into 16-bit
// halfwords, and presents the head halfword with its PC and fault flag.
module fetch_queue #(
    parameter int unsigned RV    = 32,
    parameter int unsigned VA    = RV,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect,
    input  logic [VA-1:1]       redirect_pc,
    input  logic                consume,
    output logic [15:0]         ins,
    output logic [VA-1:1]       ins_pc,
    output logic                ins_fault,
    output logic                iready,
    output logic                mem_req,
    output logic [VA-1:RV/16]   mem_addr,
    input  logic                mem_done,
    input  logic [RV-1:0]       mem_data,
    input  logic                mem_fault
);

    localparam int unsigned HW = RV / 16;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = VA - HW;
    localparam int unsigned SW = (HW > 1) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DRAIN   = 2'd2,
        FAULTED = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [15:0]     q_data  [DEPTH];
    logic            q_fault [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [VA-1:1]   head_pc_q;
    logic [WW-1:0]   wptr_q;
    logic [SW-1:0]   skip_q;

    logic            issue;
    logic            enq;
    logic            pop;
    logic            free_ok;
    logic [CW-1:0]   written;
    logic [SW-1:0]   skip_rd;

    // Head entry drives the decode-facing outputs directly from storage.
    assign ins       = q_data[head_q];
    assign ins_fault = q_fault[head_q];
    assign ins_pc    = head_pc_q;

    assign free_ok = (CW'(DEPTH) - count_q) >= CW'(HW);
    assign written = CW'(HW) - CW'(skip_q);
    assign pop     = iready & consume & ~redirect;
    assign skip_rd = (HW > 1) ? SW'(redirect_pc[SW:1]) : SW'(0);

    // Request state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; issue and enqueue strobes derived alongside.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        enq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect && free_ok) begin
                    state_d = BUSY;
                    issue   = 1'b1;
                end
            end
            BUSY: begin
                if (mem_done) begin
                    if (redirect) begin
                        state_d = IDLE;
                    end else begin
                        enq     = 1'b1;
                        state_d = mem_fault ? FAULTED : IDLE;
                    end
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_done) begin
                    state_d = IDLE;
                end
            end
            FAULTED: begin
                if (redirect) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy after this cycle's redirect, enqueue and pop.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + (enq ? written : CW'(0)) - CW'(pop);
        end
    end

    // Queue storage, pointers, fetch pointer and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i]  <= '0;
                q_fault[i] <= 1'b0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
            wptr_q    <= '0;
            skip_q    <= '0;
            iready    <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            if (redirect) begin
                tail_q    <= head_q;
                head_pc_q <= redirect_pc;
                wptr_q    <= redirect_pc[VA-1:HW];
                skip_q    <= skip_rd;
            end else begin
                if (enq) begin
                    for (int i = 0; i < HW; i++) begin
                        if (i >= int'(skip_q)) begin
                            q_data[tail_q + PW'(i) - PW'(skip_q)]  <= mem_data[16*i +: 16];
                            q_fault[tail_q + PW'(i) - PW'(skip_q)] <= mem_fault;
                        end
                    end
                    tail_q <= tail_q + PW'(written);
                    wptr_q <= wptr_q + WW'(1);
                    skip_q <= '0;
                end
                if (pop) begin
                    head_q    <= head_q + PW'(1);
                    head_pc_q <= head_pc_q + (VA-1)'(1);
                end
            end
            count_q <= count_d;
            iready  <= (count_d != '0);
            if (issue) begin
                mem_addr <= wptr_q;
            end
            mem_req <= (state_d == BUSY) || (state_d == DRAIN);
        end
    end

endmodule
